ram_wr_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared write port (port C) of the three-port word RAM. Up to NREQ requesters present an address/data pair with a level request. The block grants one request per cycle and drives the RAM write port through registered outputs, so only one source ever writes. Optionally, it zero-fills the whole RAM after reset or on command before granting anyone.

---
 rtl/ram_ctrl_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 39 +++
 rtl/ram_wr_arbiter.sv | 155 +++++++++++++++
 tb/tb_ram_wr_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg
// Shared types and constants for the port C write arbiter of the
// three-port word RAM.
//   state_e      : arbiter sequencer state (CLEAR zero-fill sweep, RUN arbitration)
//   NREQ_DEFAULT : default number of write requesters
package ram_ctrl_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam int NREQ_DEFAULT = 3;

endpackage : ram_ctrl_pkg

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin picker. The search starts at the
// requester after ptr and wraps, so the last-granted requester has the
// lowest priority on the next pick.
// Ports:
//   req [NREQ-1:0] : request vector
//   ptr [IDXW-1:0] : index of the most recently granted requester
//   gnt [NREQ-1:0] : one-hot (or zero) winner
//   idx [IDXW-1:0] : encoded winner index (0 when gnt is zero)
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDXW-1:0] idx
);

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; otherwise synthesis infers a latch.
    always_comb begin
        logic            found;
        logic [IDXW-1:0] cand;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDXW'((int'(ptr) + k) % NREQ);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/ram_wr_arbiter.sv
// ram_wr_arbiter
// Round-robin arbiter and sequencer for the RAM's shared write port C.
// One requester is accepted per cycle (combinational gnt); the accepted
// address/data are registered onto port_c_* with port_c_we one cycle later.
//
// Build option: define RAM_INIT_CLEAR_EN to implement the zero-fill sweep.
// The sweep runs after reset and on every clr pulse seen in RUN, writing 0
// to every address before any requester is granted. Without the macro the
// block resets straight into arbitration, busy is tied low and clr is ignored.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   req, gnt          : per-requester level request / same-cycle accept
//   req_addr/req_data : packed per-requester address and data
//   clr               : restart the zero-fill sweep (macro builds only)
//   busy              : zero-fill in progress (registered)
//   port_c_address/port_c_data/port_c_we : registered RAM write port
module ram_wr_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int AWIDTH = 8,
    parameter int NREQ   = NREQ_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*AWIDTH-1:0]  req_addr,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         gnt,
    input  logic                    clr,
    output logic                    busy,
    output logic [AWIDTH-1:0]       port_c_address,
    output logic [WIDTH-1:0]        port_c_data,
    output logic                    port_c_we
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IDXW-1:0]   ptr_q, ptr_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              we_q, we_d;

    logic [NREQ-1:0]   arb_gnt;
    logic [IDXW-1:0]   arb_idx;
    logic              grant_en;
    logic [AWIDTH-1:0] sel_addr;
    logic [WIDTH-1:0]  sel_data;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr_arbiter (
        .req (req),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

`ifdef RAM_INIT_CLEAR_EN
    state_e            state_q, state_d;
    logic [AWIDTH-1:0] cnt_q, cnt_d;

    // No grant during the sweep, nor in the cycle clr is seen: that request
    // would otherwise be written and then immediately overwritten by zeros.
    assign grant_en = (state_q == RUN) && !clr;
    assign busy     = (state_q == CLEAR);
`else
    logic unused_clr;
    assign unused_clr = clr;
    assign grant_en   = 1'b1;
    assign busy       = 1'b0;
`endif

    assign gnt = grant_en ? arb_gnt : '0;

    // Winner's address/data, selected by the one-hot grant.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) begin
                sel_addr = req_addr[i*AWIDTH +: AWIDTH];
                sel_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        ptr_d  = ptr_q;
        addr_d = addr_q;
        data_d = data_q;
        we_d   = 1'b0;

        if (|gnt) begin
            ptr_d  = arb_idx;
            addr_d = sel_addr;
            data_d = sel_data;
            we_d   = 1'b1;
        end

`ifdef RAM_INIT_CLEAR_EN
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                addr_d = cnt_q;
                data_d = '0;
                we_d   = 1'b1;
                cnt_d  = cnt_q + AWIDTH'(1);
                if (cnt_q == '1) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            default: state_d = RUN;
        endcase
`endif
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= IDXW'(NREQ - 1);
            addr_q <= '0;
            data_q <= '0;
            we_q   <= 1'b0;
`ifdef RAM_INIT_CLEAR_EN
            state_q <= CLEAR;
            cnt_q   <= '0;
`endif
        end else begin
            ptr_q  <= ptr_d;
            addr_q <= addr_d;
            data_q <= data_d;
            we_q   <= we_d;
`ifdef RAM_INIT_CLEAR_EN
            state_q <= state_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign port_c_address = addr_q;
    assign port_c_data    = data_q;
    assign port_c_we      = we_q;

endmodule : ram_wr_arbiter

// File: tb/tb_ram_wr_arbiter.sv
// tb_ram_wr_arbiter
// Self-checking bench for ram_wr_arbiter with a behavioural model:
// round-robin picking from the last granted index, a 1-cycle registered
// write port and, when RAM_INIT_CLEAR_EN is defined, a count of pending
// zero-fill writes.
module tb_ram_wr_arbiter;

    localparam int WIDTH  = 8;
    localparam int AWIDTH = 8;
    localparam int NREQ   = 3;
    localparam int DEPTH  = 1 << AWIDTH;
`ifdef RAM_INIT_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic                   clk;
    logic                   rst_n;
    logic [NREQ-1:0]        req;
    logic [NREQ*AWIDTH-1:0] req_addr;
    logic [NREQ*WIDTH-1:0]  req_data;
    logic [NREQ-1:0]        gnt;
    logic                   clr;
    logic                   busy;
    logic [AWIDTH-1:0]      port_c_address;
    logic [WIDTH-1:0]       port_c_data;
    logic                   port_c_we;

    int n_checks;
    int n_fail;

    // Model state
    int               m_last;
    int               m_fill_left;
    int               m_fill_addr;
    logic [AWIDTH-1:0] m_addr;
    logic [WIDTH-1:0]  m_data;
    logic              m_we;
    int                m_grant_cnt[NREQ];
    int                m_last_pick;

    ram_wr_arbiter #(
        .WIDTH  (WIDTH),
        .AWIDTH (AWIDTH),
        .NREQ   (NREQ)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req            (req),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .gnt            (gnt),
        .clr            (clr),
        .busy           (busy),
        .port_c_address (port_c_address),
        .port_c_data    (port_c_data),
        .port_c_we      (port_c_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int c = (last + k) % NREQ;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_last      = NREQ - 1;
        m_fill_left = CLR_EN ? DEPTH : 0;
        m_fill_addr = 0;
        m_addr      = '0;
        m_data      = '0;
        m_we        = 1'b0;
    endtask

    task automatic check_port(input string tag);
        n_checks++;
        if (port_c_address !== m_addr || port_c_data !== m_data ||
            port_c_we !== m_we || busy !== (m_fill_left > 0)) begin
            n_fail++;
            $display("FAIL %s @%0t: got addr=%h data=%h we=%b busy=%b, expected addr=%h data=%h we=%b busy=%b",
                     tag, $time, port_c_address, port_c_data, port_c_we, busy,
                     m_addr, m_data, m_we, (m_fill_left > 0));
        end
    endtask

    // One clock cycle: drive at negedge, check gnt, then check port_c after
    // the rising edge against the model.
    task automatic step(input string tag, input logic [NREQ-1:0] r,
                        input logic [AWIDTH-1:0] a[NREQ], input logic [WIDTH-1:0] d[NREQ],
                        input logic c);
        int pick;
        logic [NREQ-1:0] exp_gnt;
        @(negedge clk);
        req = r;
        clr = c;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AWIDTH +: AWIDTH] = a[i];
            req_data[i*WIDTH +: WIDTH]   = d[i];
        end
        #1;
        pick    = -1;
        exp_gnt = '0;
        if (m_fill_left == 0 && !(CLR_EN && c)) begin
            pick = rr_pick(r, m_last);
            if (pick >= 0) exp_gnt[pick] = 1'b1;
        end
        n_checks++;
        if (gnt !== exp_gnt) begin
            n_fail++;
            $display("FAIL %s gnt @%0t: got %b expected %b", tag, $time, gnt, exp_gnt);
        end
        m_last_pick = pick;
        @(posedge clk);
        #1;
        if (m_fill_left > 0) begin
            m_addr = AWIDTH'(m_fill_addr);
            m_data = '0;
            m_we   = 1'b1;
            m_fill_addr++;
            m_fill_left--;
        end else if (CLR_EN && c) begin
            m_fill_left = DEPTH;
            m_fill_addr = 0;
            m_we        = 1'b0;
        end else if (pick >= 0) begin
            m_addr = a[pick];
            m_data = d[pick];
            m_we   = 1'b1;
            m_last = pick;
            m_grant_cnt[pick]++;
        end else begin
            m_we = 1'b0;
        end
        check_port(tag);
    endtask

    task automatic rand_step(input string tag, input logic [NREQ-1:0] r, input logic c);
        logic [AWIDTH-1:0] a[NREQ];
        logic [WIDTH-1:0]  d[NREQ];
        for (int i = 0; i < NREQ; i++) begin
            a[i] = AWIDTH'($urandom);
            d[i] = WIDTH'($urandom);
        end
        step(tag, r, a, d, c);
    endtask

    // Apply reset and, in macro builds, run the sweep to completion.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        clr   = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        while (m_fill_left > 0) rand_step("sweep", NREQ'($urandom), 1'b0);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        req      = '0;
        clr      = 1'b0;
        req_addr = '0;
        req_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_port("reset_port");
        n_checks++;
        if (gnt !== '0) begin
            n_fail++;
            $display("FAIL reset_gnt: got %b expected 000", gnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Sweep after reset (macro) or plain random arbitration (default).
    task automatic test_post_reset();
        for (int i = 0; i < DEPTH; i++) rand_step("post_reset", NREQ'($urandom), 1'b0);
    endtask

    task automatic test_single_write();
        logic [AWIDTH-1:0] a[NREQ];
        logic [WIDTH-1:0]  d[NREQ];
        a = '{8'h11, 8'h3C, 8'h22};
        d = '{8'h44, 8'hA5, 8'h55};
        step("single_write", 3'b010, a, d, 1'b0);
        n_checks++;
        if (port_c_address !== 8'h3C || port_c_data !== 8'hA5 || port_c_we !== 1'b1) begin
            n_fail++;
            $display("FAIL single_write_abs: got %h/%h we=%b expected 3c/a5 we=1",
                     port_c_address, port_c_data, port_c_we);
        end
        rand_step("single_idle", 3'b000, 1'b0);
    endtask

    task automatic test_fairness();
        int order[$];
        do_reset();
        for (int i = 0; i < NREQ; i++) m_grant_cnt[i] = 0;
        for (int i = 0; i < 9; i++) begin
            rand_step("fairness", 3'b111, 1'b0);
            order.push_back(m_last_pick);
        end
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (order[i] != i % NREQ) begin
                n_fail++;
                $display("FAIL fairness_order[%0d]: got %0d expected %0d", i, order[i], i % NREQ);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            n_checks++;
            if (m_grant_cnt[i] != 3) begin
                n_fail++;
                $display("FAIL fairness_count[%0d]: got %0d expected 3", i, m_grant_cnt[i]);
            end
        end
    endtask

    task automatic test_skip_idle();
        // Pointer is 2 after fairness; grant 0 so the pointer sits at 0.
        rand_step("skip_setup", 3'b001, 1'b0);
        for (int i = 0; i < 6; i++) begin
            rand_step("skip_idle", 3'b101, 1'b0);
            n_checks++;
            if (port_c_we !== 1'b1 || m_last_pick != ((i % 2 == 0) ? 2 : 0)) begin
                n_fail++;
                $display("FAIL skip_idle[%0d]: got we=%b pick=%0d expected we=1 pick=%0d",
                         i, port_c_we, m_last_pick, (i % 2 == 0) ? 2 : 0);
            end
        end
    endtask

    task automatic test_clr();
        rand_step("clr_pre", 3'b001, 1'b0);
        rand_step("clr_pulse", 3'b001, 1'b1);
        while (m_fill_left > 0) rand_step("clr_sweep", 3'b001, ($urandom_range(0, 7) == 0));
        rand_step("clr_after", 3'b001, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++)
            rand_step("random", NREQ'($urandom), ($urandom_range(0, 99) == 0));
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) rand_step("rst_mid_pre", 3'b111, 1'b0);
        if (CLR_EN) begin
            rand_step("rst_mid_clr", 3'b000, 1'b1);
            for (int i = 0; i < 129; i++) rand_step("rst_mid_sweep", 3'b000, 1'b0);
        end
        @(negedge clk);
        req = '0;
        clr = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_port("rst_mid_async");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) rand_step("rst_mid_after", 3'b110, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < NREQ; i++) m_grant_cnt[i] = 0;
        m_last_pick = -1;
        test_reset();
        test_post_reset();
        test_single_write();
        test_fairness();
        test_skip_idle();
        test_clr();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish within the time bound");
        $fatal(1, "timeout");
    end

endmodule : tb_ram_wr_arbiter
